// File: rtl/btn_conditioner.sv
// Purpose: synchronize, debounce and edge-detect raw push buttons, with auto-repeat on selected buttons.
// Latency: press pulse and level change appear in the cycle after edge DEBOUNCE_CYCLES+2 of a stable new level.
// Backpressure: none; pulses are fire-and-forget and must be consumed in the cycle they are high.
module btn_conditioner #(
  parameter int               N_BTN           = 7,
  parameter int               DEBOUNCE_CYCLES = 1_000_000,
  parameter int               REPEAT_DELAY    = 40_000_000,
  parameter int               REPEAT_RATE     = 10_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 7'b0001111
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             any_pulse
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW   = $clog2(HMAX);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] DLY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RATE_LAST = HW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RPT   = 2'd2
  } rpt_state_t;

  logic [N_BTN-1:0] r_s1;
  logic [N_BTN-1:0] r_s2;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_pulse;
  logic [N_BTN-1:0] w_pulse_nxt;
  logic             r_any;

  // Two-flop synchronizer for the asynchronous button levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    logic [DW-1:0] r_dcnt;
    logic          r_lvl;
    logic          r_pls;
    logic          w_accept;
    logic          w_rise;
    logic          w_fall;
    logic          w_rpt;
    rpt_state_t    r_state;
    rpt_state_t    w_state_nxt;
    logic [HW-1:0] r_hcnt;
    logic [HW-1:0] w_hcnt_nxt;

    // A new level is accepted on the edge the counter reaches its last value.
    assign w_accept = (r_s2[g] != r_lvl) && (r_dcnt == DEB_LAST);
    assign w_rise   = w_accept &  r_s2[g];
    assign w_fall   = w_accept & ~r_s2[g];

    // Debounce: count consecutive samples that differ from the accepted level
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_dcnt <= '0;
        r_lvl  <= 1'b0;
      end else if (r_s2[g] == r_lvl) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DEB_LAST) begin
        r_lvl  <= r_s2[g];
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + DW'(1);
      end
    end

    // Repeat FSM next state; the hold counter starts on the press edge itself
    // so the first repeat lands exactly REPEAT_DELAY cycles after the press pulse.
    always_comb begin
      w_state_nxt = r_state;
      w_hcnt_nxt  = r_hcnt;
      w_rpt       = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise && REPEAT_MASK[g]) begin
            w_state_nxt = ST_FIRST;
            w_hcnt_nxt  = '0;
          end
        end
        ST_FIRST: begin
          if (w_fall || !r_lvl) begin
            w_state_nxt = ST_IDLE;
            w_hcnt_nxt  = '0;
          end else if (r_hcnt == DLY_LAST) begin
            w_rpt       = 1'b1;
            w_state_nxt = ST_RPT;
            w_hcnt_nxt  = '0;
          end else begin
            w_hcnt_nxt  = r_hcnt + HW'(1);
          end
        end
        ST_RPT: begin
          if (w_fall || !r_lvl) begin
            w_state_nxt = ST_IDLE;
            w_hcnt_nxt  = '0;
          end else if (r_hcnt == RATE_LAST) begin
            w_rpt       = 1'b1;
            w_hcnt_nxt  = '0;
          end else begin
            w_hcnt_nxt  = r_hcnt + HW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_hcnt_nxt  = '0;
        end
      endcase
    end

    // Repeat FSM state, hold counter and registered pulse
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= ST_IDLE;
        r_hcnt  <= '0;
        r_pls   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_hcnt  <= w_hcnt_nxt;
        r_pls   <= w_rise | w_rpt;
      end
    end

    assign w_pulse_nxt[g] = w_rise | w_rpt;
    assign w_level[g]     = r_lvl;
    assign w_pulse[g]     = r_pls;
  end

  // Registered OR of the pulses, aligned with btn_pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_pulse_nxt;
    end
  end

  assign btn_level = w_level;
  assign btn_pulse = w_pulse;
  assign any_pulse = r_any;

endmodule

// File: tb/tb_btn_conditioner.sv
// Purpose: directed self-checking bench for btn_conditioner with short debounce/repeat timing.
// Latency: inputs driven and outputs sampled 1 time unit after each rising clock edge.
// Backpressure: not applicable; every cycle is observed.
module tb_btn_conditioner;

  logic       clk;
  logic       reset_n;
  logic [6:0] btn_raw;
  logic [6:0] btn_level;
  logic [6:0] btn_pulse;
  logic       any_pulse;

  int total;
  int bad;
  int npls;
  int q[$];

  btn_conditioner #(
    .N_BTN          (7),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (3),
    .REPEAT_MASK    (7'b0001111)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .any_pulse(any_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, adding the number of pulses seen on bit b to npls.
  task automatic run_cnt(input int n, input int b);
    for (int k = 0; k < n; k++) begin
      tick();
      if (btn_pulse[b]) npls++;
    end
  endtask

  // Run n cycles, recording (1-based) the cycles in which bit b pulses.
  task automatic run_rec(input int n, input int b);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (btn_pulse[b]) q.push_back(k);
    end
  endtask

  int exp4[8] = '{6, 16, 19, 22, 25, 28, 31, 34};
  int exp6[3] = '{6, 16, 19};

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    btn_raw = 7'h7F;

    // 1: reset with all buttons held, then release reset
    tick();
    tick();
    check("rst_level", 32'(btn_level), 32'h00);
    check("rst_pulse", 32'(btn_pulse), 32'h00);
    check("rst_any",   32'(any_pulse), 32'h0);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("t1_e5_pulse", 32'(btn_pulse), 32'h00);
    check("t1_e5_level", 32'(btn_level), 32'h00);
    tick();
    check("t1_e6_pulse", 32'(btn_pulse), 32'h7F);
    check("t1_e6_level", 32'(btn_level), 32'h7F);
    check("t1_e6_any",   32'(any_pulse), 32'h1);
    tick();
    check("t1_e7_pulse", 32'(btn_pulse), 32'h00);
    check("t1_e7_any",   32'(any_pulse), 32'h0);
    btn_raw = 7'h00;
    for (int k = 0; k < 10; k++) tick();
    check("t1_released", 32'(btn_level), 32'h00);

    // 2: 3-cycle glitch rejected, 4-cycle press accepted once
    npls = 0;
    btn_raw[4] = 1'b1;
    run_cnt(3, 4);
    btn_raw[4] = 1'b0;
    run_cnt(12, 4);
    check("t2_glitch_pulses", 32'(npls), 32'd0);
    check("t2_glitch_level",  32'(btn_level[4]), 32'd0);
    npls = 0;
    btn_raw[4] = 1'b1;
    run_cnt(4, 4);
    btn_raw[4] = 1'b0;
    run_cnt(12, 4);
    check("t2_press_pulses", 32'(npls), 32'd1);
    check("t2_press_level",  32'(btn_level[4]), 32'd0);

    // 3: long hold of a non-repeating button
    npls = 0;
    btn_raw[5] = 1'b1;
    run_cnt(50, 5);
    check("t3_pulses", 32'(npls), 32'd1);
    btn_raw[5] = 1'b0;
    npls = 0;
    run_cnt(5, 5);
    check("t3_lvl_e5", 32'(btn_level[5]), 32'd1);
    run_cnt(1, 5);
    check("t3_lvl_e6", 32'(btn_level[5]), 32'd0);
    run_cnt(10, 5);
    check("t3_rel_pulses", 32'(npls), 32'd0);

    // 4: auto-repeat on right
    q.delete();
    btn_raw[3] = 1'b1;
    run_rec(30, 3);
    btn_raw[3] = 1'b0;
    for (int k = 31; k <= 45; k++) begin
      tick();
      if (btn_pulse[3]) q.push_back(k);
    end
    check("t4_count", 32'(q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < q.size()) check($sformatf("t4_pulse%0d", i), 32'(q[i]), 32'(exp4[i]));
      else check($sformatf("t4_missing%0d", i), 32'hFFFF_FFFF, 32'(exp4[i]));
    end

    // 5: simultaneous press of up and select
    btn_raw = 7'h11;
    for (int k = 0; k < 5; k++) tick();
    check("t5_e5_pulse", 32'(btn_pulse), 32'h00);
    tick();
    check("t5_e6_pulse", 32'(btn_pulse), 32'h11);
    check("t5_e6_any",   32'(any_pulse), 32'h1);
    tick();
    check("t5_e7_pulse", 32'(btn_pulse), 32'h00);
    check("t5_e7_any",   32'(any_pulse), 32'h0);
    btn_raw = 7'h00;
    for (int k = 0; k < 12; k++) tick();

    // 6: reset in the middle of an auto-repeat hold
    q.delete();
    btn_raw[2] = 1'b1;
    run_rec(18, 2);
    check("t6_pre_count", 32'(q.size()), 32'd2);
    reset_n = 1'b0;
    #1;
    check("t6_rst_level", 32'(btn_level), 32'h00);
    check("t6_rst_pulse", 32'(btn_pulse), 32'h00);
    check("t6_rst_any",   32'(any_pulse), 32'h0);
    tick();
    tick();
    check("t6_rst_hold_pulse", 32'(btn_pulse), 32'h00);
    reset_n = 1'b1;
    q.delete();
    run_rec(20, 2);
    check("t6_count", 32'(q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < q.size()) check($sformatf("t6_pulse%0d", i), 32'(q[i]), 32'(exp6[i]));
      else check($sformatf("t6_missing%0d", i), 32'hFFFF_FFFF, 32'(exp6[i]));
    end
    btn_raw[2] = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("t6_released", 32'(btn_level), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
